lr35902_dma: RTL
================

LR35902_DMA -- requirements
Module: lr35902_dma

Interface
REQ-001 SHALL have parameters: none; all variation is via the macro in Configuration.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  CPU clock (gbclk); all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  8  CPU write data for register FF46.
- dout  out  8  register readback.
- read  in  1  CPU read strobe (unused except for interface symmetry).
- write  in  1  CPU write strobe to FF46, already qualified by the I/O select.
- adr_rd  out  16  source address.
- rd  out  1  source read strobe.
- data_in  in  8  source data.
- adr_wr  out  8  OAM byte index.
- wr  out  1  OAM write strobe.
- data_out  out  8  byte to OAM.
- active  out  1  DMA owns the source bus and OAM.

Function
REQ-003 SHALL have the states IDLE, START and XFER, plus a 2-bit phase counter and an 8-bit byte index idx.
REQ-004 SHALL capture din into register src on any clk edge with write=1, regardless of state.
REQ-005 SHALL drive dout = src at all times.
REQ-006 SHALL, on write in any state, set idx=0 and phase=0, and enter START if START_DELAY is compiled in, else XFER.
- A write during an active transfer restarts it from the new source; the in-flight byte is not written.
REQ-007 SHALL leave START after exactly 4 clk cycles (one M-cycle) and enter XFER with phase=0.
REQ-008 SHALL, in XFER, move one byte per 4 clk cycles, with phase stepping 0,1,2,3 and wrapping to 0:
- Phases 0-2: rd=1 and adr_rd={srcmap, idx}.
- End of phase 2: latch data_in into data_out.
- Phase 3: wr=1 and adr_wr=idx; idx increments at the end of phase 3.
REQ-009 SHALL compute srcmap = src-0x20 when src>=0xE0, else src, so that FExx/FFxx sources read echo WRAM.
REQ-010 SHALL return to IDLE at the end of phase 3 when idx==159.
- The last write is to adr_wr=0x9F.
- A full transfer takes 640 clk cycles in XFER.
REQ-011 SHALL assert active=1 in START and XFER and 0 in IDLE.
REQ-012 SHALL keep rd=0 and wr=0 outside XFER.
REQ-013 SHALL hold adr_rd, adr_wr and data_out at their last values when idle; their idle values are don't-care to consumers.
REQ-014 SHALL, if write and the final phase 3 coincide, give the restart priority: the final byte is still written and the state goes to START/XFER, not IDLE.

Reset
REQ-015 SHALL, when reset=1 at a clk edge, set:
- state=IDLE, phase=0, idx=0.
- src=0xFF, data_out=0x00.
- active=0, rd=0, wr=0.
REQ-016 SHALL give reset priority over a simultaneous write.
REQ-017 SHALL abort a transfer on reset with no further wr pulses.

Configuration
REQ-018 SHALL honour macro LR35902_DMA_START_DELAY_EN:
- Defined: the START state exists (REQ-007); write to first rd is 4 cycles.
- Undefined: the START logic is not synthesised, and a write enters XFER directly with rd=1 on the following cycle.

Verification
REQ-019 Write 0xC1 with the macro defined -> active=1 on the next cycle; first rd with adr_rd=0xC100 after 4 cycles; 160 wr pulses on adr_wr 0x00..0x9F; active=0 after 644 cycles total.
REQ-020 Write 0xFE -> adr_rd sequence is 0xDE00..0xDE9F; dout reads 0xFE.
REQ-021 Write 0x80, then write 0xC0 at idx=50 phase 1 -> byte 50 from 0x80 is never written; the transfer restarts at 0xC000 with adr_wr=0x00.
REQ-022 Assert reset during XFER at idx=10 -> active=0, rd=wr=0 next cycle; dout=0xFF; no further wr pulses.
REQ-023 Drive data_in=idx^0x5A from a source model -> OAM model holds byte k = k^0x5A for k = 0..159.
REQ-024 With the macro undefined, write 0xC0 -> rd=1 with adr_rd=0xC000 on the next cycle; active=0 after 640 cycles.

Source files
------------

// File: rtl/lr35902_dma_if.sv
// Bus bundle for the LR35902 OAM DMA: CPU register port, source read port and OAM write port.
interface lr35902_dma_if;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        read;
    logic        write;
    logic [15:0] adr_rd;
    logic        rd;
    logic [7:0]  data_in;
    logic [7:0]  adr_wr;
    logic        wr;
    logic [7:0]  data_out;
    logic        active;

    modport slave (
        input  din, read, write, data_in,
        output dout, adr_rd, rd, adr_wr, wr, data_out, active
    );

    modport master (
        output din, read, write, data_in,
        input  dout, adr_rd, rd, adr_wr, wr, data_out, active
    );
endinterface

// File: rtl/lr35902_dma.sv
// LR35902 OAM DMA engine: copies 160 bytes from {src,00} to OAM, one byte per M-cycle.
// Define LR35902_DMA_START_DELAY_EN to add a one M-cycle START state before the copy.
module lr35902_dma (
    input  logic          clk,
    input  logic          reset,
    lr35902_dma_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;
    logic [7:0] dataOut_q, dataOut_d;
    logic [7:0] srcMap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            idx_q     <= 8'd0;
            src_q     <= 8'hFF;
            dataOut_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            src_q     <= src_d;
            dataOut_q <= dataOut_d;
        end
    end

    // Sources at E0xx and above are folded down onto echo WRAM.
    always_comb begin
        srcMap = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        src_d     = src_q;
        dataOut_d = dataOut_q;

        case (state_q)
`ifdef LR35902_DMA_START_DELAY_EN
            START: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = XFER;
                end
            end
`endif
            XFER: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd2) begin
                    dataOut_d = bus.data_in;
                end
                if (phase_q == 2'd3) begin
                    if (idx_q == 8'd159) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase

        // A CPU write always wins and restarts the copy from the new source.
        if (bus.write) begin
            src_d   = bus.din;
            idx_d   = 8'd0;
            phase_d = 2'd0;
`ifdef LR35902_DMA_START_DELAY_EN
            state_d = START;
`else
            state_d = XFER;
`endif
        end
    end

    assign bus.dout     = src_q;
    assign bus.active   = (state_q != IDLE);
    assign bus.rd       = (state_q == XFER) && (phase_q != 2'd3);
    assign bus.wr       = (state_q == XFER) && (phase_q == 2'd3);
    assign bus.adr_rd   = {srcMap, idx_q};
    assign bus.adr_wr   = idx_q;
    assign bus.data_out = dataOut_q;
endmodule
